// File: rtl/host_pkg.sv
// rtl/host_pkg.sv - shared op encodings, FSM states and address widths for the host loader
package host_pkg;

    localparam int IMEM_AW = 9;
    localparam int DMEM_AW = 8;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        OP_WR_IMEM = 2'd0,
        OP_WR_DMEM = 2'd1,
        OP_RD_DMEM = 2'd2,
        OP_RUN     = 2'd3
    } host_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RUN   = 3'd3,
        ST_RESP  = 3'd4
    } host_state_t;

endpackage

// File: rtl/host_run_timer.sv
// rtl/host_run_timer.sv - loadable saturating down-counter that flags its final cycle
module host_run_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // High during the last counted cycle so the owner can leave its state on time.
    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/host_mem_loader.sv
// rtl/host_mem_loader.sv - host command initiator driving pipeline memories and the core reset
module host_mem_loader
    import host_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [IMEM_AW-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]    cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    output logic                 rsp_err,
    output logic                 cpu_rst,
    output logic                 write_to_imem,
    output logic [IMEM_AW-1:0]   addr_imem_host,
    output logic [DATA_W-1:0]    data_imem_host,
    output logic                 write_to_dmem,
    output logic [DMEM_AW-1:0]   addr_dmem_host,
    output logic [DATA_W-1:0]    data_dmem_host,
    output logic                 read_req_dmem,
    input  logic [DATA_W-1:0]    data_out_dmem
);

    // Bits of cmd_data that must be zero for a RUN count to fit the counter.
    localparam logic [DATA_W-1:0] RUN_HI_MASK = ~DATA_W'((33'd1 << CNT_W) - 33'd1);

    host_state_t          state_q, state_d;
    logic                 cmd_ready_d, cpu_rst_d;
    logic                 wr_imem_d, wr_dmem_d, rd_req_d;
    logic [IMEM_AW-1:0]   addr_imem_d;
    logic [DATA_W-1:0]    data_imem_d, data_dmem_d;
    logic [DMEM_AW-1:0]   addr_dmem_d;
    logic                 rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0]    rsp_data_d;
    logic [CNT_W-1:0]     run_len_q, run_len_d;
    logic                 tmr_load, tmr_done;
    logic [CNT_W-1:0]     tmr_val;
    logic                 accept, addr_bad, run_bad, run_zero;

    assign accept   = cmd_valid && cmd_ready;
    assign addr_bad = cmd_addr[IMEM_AW-1];
    assign run_bad  = |(cmd_data & RUN_HI_MASK);
    assign run_zero = (cmd_data[CNT_W-1:0] == '0);

    host_run_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        cpu_rst_d   = 1'b1;
        wr_imem_d   = 1'b0;
        wr_dmem_d   = 1'b0;
        rd_req_d    = 1'b0;
        addr_imem_d = addr_imem_host;
        data_imem_d = data_imem_host;
        addr_dmem_d = addr_dmem_host;
        data_dmem_d = data_dmem_host;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        run_len_d   = run_len_q;
        tmr_load    = 1'b0;
        tmr_val     = cmd_data[CNT_W-1:0];

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    case (host_op_t'(cmd_op))
                        OP_WR_IMEM: begin
                            state_d     = ST_WRITE;
                            wr_imem_d   = 1'b1;
                            addr_imem_d = cmd_addr;
                            data_imem_d = cmd_data;
                        end
                        OP_WR_DMEM: begin
                            if (addr_bad) begin
                                state_d     = ST_RESP;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                            end else begin
                                state_d     = ST_WRITE;
                                wr_dmem_d   = 1'b1;
                                addr_dmem_d = cmd_addr[DMEM_AW-1:0];
                                data_dmem_d = cmd_data;
                            end
                        end
                        OP_RD_DMEM: begin
                            if (addr_bad) begin
                                state_d     = ST_RESP;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                            end else begin
                                state_d     = ST_READ;
                                rd_req_d    = 1'b1;
                                addr_dmem_d = cmd_addr[DMEM_AW-1:0];
                                tmr_load    = 1'b1;
                                tmr_val     = CNT_W'(RD_LAT);
                            end
                        end
                        OP_RUN: begin
                            if (run_bad) begin
                                state_d     = ST_RESP;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                            end else if (run_zero) begin
                                state_d     = ST_RESP;
                                rsp_valid_d = 1'b1;
                            end else begin
                                state_d   = ST_RUN;
                                cpu_rst_d = 1'b0;
                                tmr_load  = 1'b1;
                                run_len_d = cmd_data[CNT_W-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
            end
            ST_READ: begin
                rd_req_d = 1'b1;
                if (tmr_done) begin
                    rd_req_d    = 1'b0;
                    rsp_data_d  = data_out_dmem;
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                cpu_rst_d = 1'b0;
                if (tmr_done) begin
                    cpu_rst_d   = 1'b1;
                    rsp_data_d  = DATA_W'(run_len_q);
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d    = ST_IDLE;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cmd_ready      <= 1'b0;
            cpu_rst        <= 1'b1;
            write_to_imem  <= 1'b0;
            write_to_dmem  <= 1'b0;
            read_req_dmem  <= 1'b0;
            addr_imem_host <= '0;
            data_imem_host <= '0;
            addr_dmem_host <= '0;
            data_dmem_host <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            run_len_q      <= '0;
        end else begin
            state_q        <= state_d;
            cmd_ready      <= cmd_ready_d;
            cpu_rst        <= cpu_rst_d;
            write_to_imem  <= wr_imem_d;
            write_to_dmem  <= wr_dmem_d;
            read_req_dmem  <= rd_req_d;
            addr_imem_host <= addr_imem_d;
            data_imem_host <= data_imem_d;
            addr_dmem_host <= addr_dmem_d;
            data_dmem_host <= data_dmem_d;
            rsp_valid      <= rsp_valid_d;
            rsp_data       <= rsp_data_d;
            rsp_err        <= rsp_err_d;
            run_len_q      <= run_len_d;
        end
    end

endmodule
